// File: rtl/vga_pkg.sv
// Shared key codes, PS/2 set-2 scan-code constants and the scan-to-key
// lookup used by the keyboard decoder.
//   key_* : 4-bit codes for the currently held key (key_relesed = none held)
//   SC_*  : set-2 make codes, plus the break (F0) and extended (E0) prefixes
//   scan_to_key() : returns {valid, code}; valid is low for unmapped bytes
package vga_pkg;

    localparam logic [3:0] key_relesed = 4'd0;
    localparam logic [3:0] key_A       = 4'd1;
    localparam logic [3:0] key_S       = 4'd2;
    localparam logic [3:0] key_W       = 4'd3;
    localparam logic [3:0] key_D       = 4'd4;
    localparam logic [3:0] key_1       = 4'd5;
    localparam logic [3:0] key_2       = 4'd6;
    localparam logic [3:0] key_3       = 4'd7;
    localparam logic [3:0] key_4       = 4'd8;
    localparam logic [3:0] key_esc     = 4'd9;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_4     = 8'h25;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } key_map_t;

    function automatic key_map_t scan_to_key(input logic [7:0] sc);
        key_map_t m;
        m.valid = 1'b1;
        m.code  = key_relesed;
        case (sc)
            SC_A:    m.code = key_A;
            SC_S:    m.code = key_S;
            SC_W:    m.code = key_W;
            SC_D:    m.code = key_D;
            SC_1:    m.code = key_1;
            SC_2:    m.code = key_2;
            SC_3:    m.code = key_3;
            SC_4:    m.code = key_4;
            SC_ESC:  m.code = key_esc;
            default: m.valid = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream to "currently held key" decoder.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   rx_data   : received byte, qualified by rx_valid
//   rx_valid  : one-cycle strobe
//   key_code  : held key (key_relesed when nothing held)
//   key_event : one-cycle pulse whenever key_code changes
//
// state   | meaning
// --------+-------------------------------------------
// IDLE    | waiting for a make code or a prefix
// BRK     | F0 seen, next byte is a released key
// EXT     | E0 seen, extended key (ignored)
// EXT_BRK | E0 F0 seen, extended release (ignored)
module ps2_key_decoder
    import vga_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 650_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] key_code,
    output logic       key_event
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    key_code_q;
    logic          key_event_q;
    key_map_t      map_w;

    assign map_w     = scan_to_key(rx_data);
    assign key_code  = key_code_q;
    assign key_event = key_event_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_code_q  <= key_relesed;
            key_event_q <= 1'b0;
        end else begin
            key_event_q <= 1'b0;
            if (rx_valid) begin
                // A byte always wins over a timeout firing in the same cycle.
                cnt_q <= '0;
                if (rx_data == SC_BREAK) begin
                    // E0 F0 is the only path into EXT_BRK; F0 anywhere else
                    // (including a repeated F0) restarts a plain break.
                    state_q <= (state_q == EXT) ? EXT_BRK : BRK;
                end else if (rx_data == SC_EXT) begin
                    state_q <= EXT;
                end else begin
                    state_q <= IDLE;
                    case (state_q)
                        IDLE: begin
                            // Typematic repeats of the held key stay silent.
                            if (map_w.valid && map_w.code != key_code_q) begin
                                key_code_q  <= map_w.code;
                                key_event_q <= 1'b1;
                            end
                        end
                        BRK: begin
                            // Releasing a key other than the held one is a no-op.
                            if (map_w.valid && map_w.code == key_code_q) begin
                                key_code_q  <= key_relesed;
                                key_event_q <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (state_q != IDLE) begin
                if (cnt_q == TO_LAST) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;
    import vga_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] key_code;
    logic       key_event;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .key_code(key_code), .key_event(key_event)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nbad = 0;
    int cyc  = 0;
    int ev_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (key_event === 1'b1) ev_seen++;

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the decoder is "a pending prefix (break and/or
    // extended) that expires after TO quiet cycles, plus the held key".
    logic [3:0] kmap [int];
    int  m_key = 0;
    bit  m_brk = 0;
    bit  m_ext = 0;
    int  m_last = 0;
    int  m_evs  = 0;
    int  m_exp_ev = 0;

    function automatic void model_byte(input int b, input int edge_idx);
        int old;
        // Prefix abandoned if more than TO clock edges passed since it arrived.
        if ((m_brk || m_ext) && (edge_idx - m_last) > TO) begin
            m_brk = 0; m_ext = 0;
        end
        m_last = edge_idx;
        old = m_key;
        if (b == 'hF0) begin
            m_brk = 1;
            m_ext = (m_ext && !m_brk_was()) ? 1 : 0;
        end else if (b == 'hE0) begin
            m_ext = 1; m_brk = 0;
        end else begin
            if (!m_brk && !m_ext) begin
                if (kmap.exists(b)) m_key = kmap[b];
            end else if (m_brk && !m_ext) begin
                if (kmap.exists(b) && kmap[b] == m_key) m_key = 0;
            end
            m_brk = 0; m_ext = 0;
        end
        m_exp_ev = (m_key != old) ? 1 : 0;
        m_evs += m_exp_ev;
    endfunction

    // Helper so that "E0 then F0" keeps the extended flag while any other
    // F0 (after F0 or after E0 F0) is a plain break.
    bit m_brk_prev = 0;
    function automatic bit m_brk_was();
        return m_brk_prev;
    endfunction

    task automatic send(input int b);
        @(negedge clk);
        rst = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'(b);
        m_brk_prev = m_brk;
        model_byte(b, cyc + 1);
        @(posedge clk);
        #1;
        check($sformatf("key_code after %02h", b), int'(key_code), m_key);
        check($sformatf("key_event after %02h", b), int'(key_event), m_exp_ev);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b1;       // reset must override a concurrent byte
        rx_data = SC_ESC;
        @(posedge clk);
        #1;
        m_key = 0; m_brk = 0; m_ext = 0;
        check("reset key_code", int'(key_code), 0);
        check("reset key_event", int'(key_event), 0);
        @(negedge clk);
        rst = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic check_events(input string tag);
        idle(2);
        check(tag, ev_seen, m_evs);
    endtask

    initial begin
        int b, g, r;
        int pool [13] = '{'h1C, 'h1B, 'h1D, 'h23, 'h16, 'h1E, 'h26, 'h25, 'h76,
                          'hF0, 'hE0, 'h75, 'h5A};
        kmap['h1C] = key_A;  kmap['h1B] = key_S; kmap['h1D] = key_W;
        kmap['h23] = key_D;  kmap['h16] = key_1; kmap['h1E] = key_2;
        kmap['h26] = key_3;  kmap['h25] = key_4; kmap['h76] = key_esc;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();
        check_events("events after reset");

        // W press and release
        send('h1D); send('hF0); send('h1D);
        check_events("events W press/release");

        // typematic repeat of A
        send('h1C); send('h1C); send('h1C);
        check_events("events A typematic");

        // A then D, then release of A does nothing
        send('h23); send('hF0); send('h1C);
        check("held D after break A", int'(key_code), key_D);
        check_events("events A/D");
        send('hF0); send('h23);

        // extended keys ignored, then back to IDLE
        send('hE0); send('h75); send('hE0); send('hF0); send('h75); send('h5A);
        check("ext leaves released", int'(key_code), key_relesed);
        send('h1C);
        check("idle after ext", int'(key_code), key_A);
        check_events("events extended");
        send('hF0); send('h1C);

        // timeout: F0, 20 quiet cycles, 76 is a make code
        send('hF0); idle(20); send('h76);
        check("timeout make esc", int'(key_code), key_esc);
        check_events("events timeout");

        // reset discards a pending break
        send('h16); send('hF0);
        do_reset();
        send('h16);
        check("key_1 after reset", int'(key_code), key_1);
        check_events("events reset mid-seq");

        // randomized stream, back-to-back bytes and long gaps mixed
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else begin
                if (r < 60)      g = 0;
                else if (r < 90) g = $urandom_range(1, 4);
                else             g = $urandom_range(TO + 2, TO + 10);
                if (g > 0) idle(g);
                if ($urandom_range(0, 9) == 0) b = $urandom_range(0, 255);
                else b = pool[$urandom_range(0, 12)];
                send(b);
            end
        end
        check_events("events random");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 650_000: idle cycles after a prefix byte before the sequence is abandoned (10 ms at 65 MHz).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rx_data  input  8  received PS/2 set-2 byte, qualified by rx_valid.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-006 key_code  output  4  currently held key, encoded with the shared key codes (key_relesed, key_A ... key_esc).
REQ-007 key_event  output  1  one-cycle pulse when key_code changes value.

Function
REQ-008 The FSM SHALL have states IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-009 In IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code, and the FSM stays in IDLE.
REQ-010 Make-code mapping: 1C->key_A, 1B->key_S, 1D->key_W, 23->key_D, 16->key_1, 1E->key_2, 26->key_3, 25->key_4, 76->key_esc.
REQ-011 A mapped make code SHALL load key_code; an unmapped make code leaves key_code unchanged.
REQ-012 In BRK: a non-prefix byte -> IDLE; if it maps to the current key_code, key_code becomes key_relesed, otherwise no change.
REQ-013 In EXT: F0 -> EXT_BRK; any other byte -> IDLE with no key_code change (extended keys ignored).
REQ-014 In EXT_BRK: any byte -> IDLE with no key_code change.
REQ-015 A prefix byte in BRK, EXT or EXT_BRK SHALL restart the sequence: F0 -> BRK, E0 -> EXT.
REQ-016 Latency: key_code and key_event SHALL update on the first rising edge after the rx_valid cycle that carries the final byte.
REQ-017 key_event SHALL be high for exactly one cycle, and only when the new key_code differs from the old one.
REQ-018 Typematic repeat of the held make code SHALL produce no key_event.
REQ-019 Timeout counter SHALL clear on every rx_valid and increment each cycle while the FSM is not in IDLE.
REQ-020 On reaching TIMEOUT_CYCLES-1 with rx_valid low, the FSM SHALL return to IDLE with no key_code change.
REQ-021 If rx_valid is high in the cycle the timeout would fire, the byte SHALL be processed in the current state and the timeout SHALL NOT apply.
REQ-022 Counter width SHALL be $clog2(TIMEOUT_CYCLES); the counter SHALL saturate and never wrap.
REQ-023 Bytes arriving on consecutive cycles SHALL each be processed; no input is dropped.

Reset
REQ-024 With rst high at a clock edge: FSM -> IDLE, counter -> 0, key_code -> key_relesed, key_event -> 0.
REQ-025 rst SHALL override rx_valid in the same cycle; a partial sequence in progress at reset is discarded.

Structure
REQ-026 Scan-code constants (SC_A, SC_S, SC_W, SC_D, SC_1..SC_4, SC_ESC, SC_BREAK=F0, SC_EXT=E0) SHALL live in vga_pkg alongside the existing key codes.
REQ-027 The scan-to-key mapping SHALL be a function in vga_pkg, returning a valid flag plus a 4-bit code.
REQ-028 The state enum SHALL be local to the module; no sub-module is required.

Verification
REQ-029 Bytes 1D, F0, 1D -> after byte 1: key_code=key_W, one key_event; after byte 3: key_code=key_relesed, one key_event.
REQ-030 Bytes 1C, 1C, 1C -> key_code=key_A with a single key_event total.
REQ-031 Bytes 1C, 23, F0 1C -> key_code=key_D; the break of A causes no change and no key_event.
REQ-032 Bytes E0 75, then E0 F0 75, then 5A -> key_code stays key_relesed, no key_event, FSM back in IDLE.
REQ-033 TIMEOUT_CYCLES=16; F0 then 20 idle cycles then 76 -> key_code=key_esc (treated as a make code).
REQ-034 Send 16 (key_1), then F0, then assert rst for 1 cycle, then send 16 -> key_relesed after reset, then key_1 with a key_event.
